// File: rtl/ct_pkg.sv
// ---------------------------------------------------------------------------
// ct_pkg
// Shared definitions for the ciphertext memory (ct_mem) and the logic that
// reads it on behalf of the crack cores.
//   CT_AW / CT_DW : ct_mem address / data width
//   CT_RD_LAT     : ct_mem read latency (address presented -> data valid)
//   ct_addr_t     : ct_mem address type
//   ct_byte_t     : one ciphertext byte
// ---------------------------------------------------------------------------
package ct_pkg;

   localparam int CT_AW     = 8;
   localparam int CT_DW     = 8;
   localparam int CT_RD_LAT = 1;

   typedef logic [CT_AW-1:0] ct_addr_t;
   typedef logic [CT_DW-1:0] ct_byte_t;

endpackage

// File: rtl/ct_read_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Round-robin priority picker: returns the first asserted request found by
// searching upward from i_ptr with wrap-around modulo NREQ.
// Ports:
//   i_req  : per-requester request vector
//   i_ptr  : index with highest priority this cycle (must be < NREQ)
//   o_gnt  : one-hot winner (all zero when no request)
//   o_idx  : encoded index of the winner (0 when no request)
//   o_any  : at least one request present
// ---------------------------------------------------------------------------
module rr_pick #(
   parameter int NREQ = 2,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [IW-1:0]   o_idx,
   output logic            o_any
);

   int w_j;

   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_j   = 0;
      for (int k = 0; k < NREQ; k++) begin
         // i_ptr < NREQ, so a single subtraction is enough to wrap
         w_j = int'(i_ptr) + k;
         if (w_j >= NREQ) w_j = w_j - NREQ;
         if (!o_any && i_req[w_j]) begin
            o_any      = 1'b1;
            o_gnt[w_j] = 1'b1;
            o_idx      = IW'(w_j);
         end
      end
   end

endmodule

// File: rtl/ct_read_arbiter.sv
// ---------------------------------------------------------------------------
// ct_read_arbiter
// Shares the single-port ciphertext memory between NREQ crack cores. One
// byte read is granted per cycle (round-robin, with optional burst lock),
// the granted address goes to ct_mem in the same cycle, and the returned
// byte is handed back with a per-core valid pulse RD_LAT cycles later.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req        : per-core read request (level, held until granted)
//   lock       : per-core burst lock, honoured only at grant time
//   req_addr   : per-core address, slice i belongs to core i
//   gnt        : one-hot grant (combinational)
//   rvalid     : one-hot return pulse, rdata valid for that core
//   rdata      : returned byte, broadcast to all cores
//   ct_addr    : ct_mem address (holds last value when idle)
//   ct_wrdata  : ct_mem write data, tied to 0
//   ct_wren    : ct_mem write enable, tied to 0
//   ct_rddata  : ct_mem read data
//   busy       : any request pending or any read in flight
// ---------------------------------------------------------------------------
module ct_read_arbiter
   import ct_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int RD_LAT = CT_RD_LAT,
   parameter int AW     = CT_AW
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    lock,
   input  logic [NREQ*AW-1:0] req_addr,
   output logic [NREQ-1:0]    gnt,
   output logic [NREQ-1:0]    rvalid,
   output ct_byte_t           rdata,
   output logic [AW-1:0]      ct_addr,
   output ct_byte_t           ct_wrdata,
   output logic               ct_wren,
   input  ct_byte_t           ct_rddata,
   output logic               busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [IW-1:0]   r_rr_ptr;
   logic            r_own_vld;
   logic [IW-1:0]   r_own_idx;
   logic [AW-1:0]   r_last_addr;
   // One-hot requester id per pipeline stage; all-zero marks a bubble
   logic [NREQ-1:0] r_id_p [RD_LAT];

   logic [NREQ-1:0] w_pick_gnt;
   logic [IW-1:0]   w_pick_idx;
   logic            w_pick_any;
   logic            w_own_hit;
   logic [NREQ-1:0] w_gnt;
   logic [IW-1:0]   w_idx;
   logic            w_any;
   logic [AW-1:0]   w_sel_addr;
   logic [IW-1:0]   w_next_ptr;
   logic            w_pipe_busy;

   rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr_pick (
      .i_req (req),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_pick_gnt),
      .o_idx (w_pick_idx),
      .o_any (w_pick_any)
   );

   // A lock owner that dropped req loses the grant immediately and the
   // round-robin picker decides within the same cycle.
   assign w_own_hit = r_own_vld & req[r_own_idx];

   always_comb begin
      w_gnt = '0;
      w_idx = '0;
      w_any = 1'b0;
      if (!rst) begin
         if (w_own_hit) begin
            w_gnt[r_own_idx] = 1'b1;
            w_idx            = r_own_idx;
            w_any            = 1'b1;
         end else begin
            w_gnt = w_pick_gnt;
            w_idx = w_pick_idx;
            w_any = w_pick_any;
         end
      end
   end

   assign w_sel_addr = req_addr[int'(w_idx)*AW +: AW];
   assign w_next_ptr = (w_idx == IW'(NREQ-1)) ? '0 : w_idx + IW'(1);

   always_comb begin
      w_pipe_busy = 1'b0;
      for (int k = 0; k < RD_LAT; k++) begin
         w_pipe_busy = w_pipe_busy | (|r_id_p[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr    <= '0;
         r_own_vld   <= 1'b0;
         r_own_idx   <= '0;
         r_last_addr <= '0;
         for (int k = 0; k < RD_LAT; k++) begin
            r_id_p[k] <= '0;
         end
      end else begin
         if (w_any) begin
            r_rr_ptr    <= w_next_ptr;
            r_last_addr <= w_sel_addr;
         end
         // Lock is sampled only for the core that wins this cycle
         r_own_vld <= w_any & lock[w_idx];
         r_own_idx <= w_idx;
         // --- stage p0: grant issued, address at ct_mem ---
         r_id_p[0] <= w_gnt;
         // --- stages p1..: follow ct_mem read latency ---
         for (int k = 1; k < RD_LAT; k++) begin
            r_id_p[k] <= r_id_p[k-1];
         end
      end
   end

   // --- return stage: last pipeline entry lines up with ct_rddata ---
   assign rvalid    = r_id_p[RD_LAT-1];
   assign rdata     = (|r_id_p[RD_LAT-1]) ? ct_rddata : '0;

   assign gnt       = w_gnt;
   assign ct_addr   = w_any ? w_sel_addr : r_last_addr;
   assign ct_wrdata = '0;
   assign ct_wren   = 1'b0;
   assign busy      = (|req) | w_pipe_busy;

endmodule

// File: tb/tb_ct_read_arbiter.sv
module tb_ct_read_arbiter;

   logic        clk;
   int          nvec;
   int          nfail;

   // two-requester instance, RD_LAT = 1
   logic        rst2;
   logic [1:0]  req2, lock2, gnt2, rvalid2;
   logic [15:0] addr2;
   logic [7:0]  rdata2, ct_addr2, ct_wrdata2, ct_rddata2;
   logic        ct_wren2, busy2;

   // three-requester instance, RD_LAT = 3
   logic        rst3;
   logic [2:0]  req3, lock3, gnt3, rvalid3;
   logic [23:0] addr3;
   logic [7:0]  rdata3, ct_addr3, ct_wrdata3, ct_rddata3;
   logic        ct_wren3, busy3;

   logic [7:0]  m2 [1];
   logic [7:0]  m3 [3];

   ct_read_arbiter #(.NREQ(2), .RD_LAT(1), .AW(8)) dut2 (
      .clk(clk), .rst(rst2), .req(req2), .lock(lock2), .req_addr(addr2),
      .gnt(gnt2), .rvalid(rvalid2), .rdata(rdata2), .ct_addr(ct_addr2),
      .ct_wrdata(ct_wrdata2), .ct_wren(ct_wren2), .ct_rddata(ct_rddata2),
      .busy(busy2)
   );

   ct_read_arbiter #(.NREQ(3), .RD_LAT(3), .AW(8)) dut3 (
      .clk(clk), .rst(rst3), .req(req3), .lock(lock3), .req_addr(addr3),
      .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3), .ct_addr(ct_addr3),
      .ct_wrdata(ct_wrdata3), .ct_wren(ct_wren3), .ct_rddata(ct_rddata3),
      .busy(busy3)
   );

   // memory contents: mem[a] = 7*a + 0x19 (mod 256); mem[5] = 0x3C
   function automatic logic [7:0] memf(input logic [7:0] a);
      return 8'(a * 8'd7 + 8'h19);
   endfunction

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      m2[0] <= memf(ct_addr2);
      m3[0] <= memf(ct_addr3);
      m3[1] <= m3[0];
      m3[2] <= m3[1];
   end
   assign ct_rddata2 = m2[0];
   assign ct_rddata3 = m3[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step2(input logic [1:0] r, input logic [1:0] l,
                        input logic [7:0] a0, input logic [7:0] a1);
      @(negedge clk);
      req2  = r;
      lock2 = l;
      addr2 = {a1, a0};
      #1;
   endtask

   task automatic exp2(input string tag, input logic [1:0] eg, input logic [7:0] ea,
                       input logic [1:0] ev, input logic [7:0] ed);
      chk($sformatf("%s.gnt", tag), 32'(gnt2), 32'(eg));
      chk($sformatf("%s.addr", tag), 32'(ct_addr2), 32'(ea));
      chk($sformatf("%s.rvalid", tag), 32'(rvalid2), 32'(ev));
      if (ev != 2'b00) chk($sformatf("%s.rdata", tag), 32'(rdata2), 32'(ed));
   endtask

   task automatic step3(input logic [2:0] r, input logic [7:0] a0,
                        input logic [7:0] a1, input logic [7:0] a2);
      @(negedge clk);
      req3  = r;
      addr3 = {a2, a1, a0};
      #1;
   endtask

   task automatic exp3(input string tag, input logic [2:0] eg, input logic [7:0] ea,
                       input logic [2:0] ev, input logic [7:0] ed);
      chk($sformatf("%s.gnt", tag), 32'(gnt3), 32'(eg));
      chk($sformatf("%s.addr", tag), 32'(ct_addr3), 32'(ea));
      chk($sformatf("%s.rvalid", tag), 32'(rvalid3), 32'(ev));
      if (ev != 3'b000) chk($sformatf("%s.rdata", tag), 32'(rdata3), 32'(ed));
   endtask

   initial begin
      nvec  = 0;
      nfail = 0;
      rst2  = 1'b1;  req2 = '0;  lock2 = '0;  addr2 = '0;
      rst3  = 1'b1;  req3 = '0;  lock3 = '0;  addr3 = '0;
      repeat (3) @(negedge clk);
      rst2 = 1'b0;
      rst3 = 1'b0;
      #1;

      // reset values
      chk("rst.gnt2", 32'(gnt2), 32'h0);
      chk("rst.rvalid2", 32'(rvalid2), 32'h0);
      chk("rst.rdata2", 32'(rdata2), 32'h0);
      chk("rst.addr2", 32'(ct_addr2), 32'h0);
      chk("rst.busy2", 32'(busy2), 32'h0);
      chk("rst.wren2", 32'(ct_wren2), 32'h0);
      chk("rst.wrdata2", 32'(ct_wrdata2), 32'h0);
      chk("rst.busy3", 32'(busy3), 32'h0);

      // both cores, no lock: alternate 0,1,0,1 starting from rr pointer 0
      step2(2'b11, 2'b00, 8'h10, 8'h20); exp2("alt1", 2'b01, 8'h10, 2'b00, 8'h00);
      step2(2'b11, 2'b00, 8'h11, 8'h20); exp2("alt2", 2'b10, 8'h20, 2'b01, memf(8'h10));
      step2(2'b11, 2'b00, 8'h11, 8'h21); exp2("alt3", 2'b01, 8'h11, 2'b10, memf(8'h20));
      step2(2'b11, 2'b00, 8'h12, 8'h21); exp2("alt4", 2'b10, 8'h21, 2'b01, memf(8'h11));
      step2(2'b00, 2'b00, 8'h12, 8'h21); exp2("alt5", 2'b00, 8'h21, 2'b10, memf(8'h21));

      // single core read of addr 5 (mem = 0x3C)
      step2(2'b01, 2'b00, 8'h05, 8'h21); exp2("one1", 2'b01, 8'h05, 2'b00, 8'h00);
      chk("one1.busy", 32'(busy2), 32'h1);
      step2(2'b00, 2'b00, 8'h05, 8'h21); exp2("one2", 2'b00, 8'h05, 2'b01, 8'h3C);
      chk("one2.busy", 32'(busy2), 32'h1);
      step2(2'b00, 2'b00, 8'h05, 8'h21); exp2("one3", 2'b00, 8'h05, 2'b00, 8'h00);
      chk("one3.busy", 32'(busy2), 32'h0);

      // single read by core 1 (rr pointer points at core 1)
      step2(2'b10, 2'b00, 8'h05, 8'h40); exp2("c1a", 2'b10, 8'h40, 2'b00, 8'h00);
      step2(2'b00, 2'b00, 8'h05, 8'h40); exp2("c1b", 2'b00, 8'h40, 2'b10, memf(8'h40));

      // core 0 locked burst of addr 1..4 while core 1 requests
      step2(2'b11, 2'b01, 8'h01, 8'h80); exp2("lk1", 2'b01, 8'h01, 2'b00, 8'h00);
      step2(2'b11, 2'b01, 8'h02, 8'h80); exp2("lk2", 2'b01, 8'h02, 2'b01, memf(8'h01));
      step2(2'b11, 2'b01, 8'h03, 8'h80); exp2("lk3", 2'b01, 8'h03, 2'b01, memf(8'h02));
      step2(2'b11, 2'b01, 8'h04, 8'h80); exp2("lk4", 2'b01, 8'h04, 2'b01, memf(8'h03));
      step2(2'b10, 2'b00, 8'h04, 8'h80); exp2("lk5", 2'b10, 8'h80, 2'b01, memf(8'h04));
      step2(2'b00, 2'b00, 8'h04, 8'h80); exp2("lk6", 2'b00, 8'h80, 2'b10, memf(8'h80));

      // owner releases lock while core 1 waits: owner still gets that grant
      step2(2'b11, 2'b01, 8'h09, 8'h81); exp2("rel1", 2'b01, 8'h09, 2'b00, 8'h00);
      step2(2'b11, 2'b00, 8'h0A, 8'h81); exp2("rel2", 2'b01, 8'h0A, 2'b01, memf(8'h09));
      step2(2'b11, 2'b00, 8'h0B, 8'h81); exp2("rel3", 2'b10, 8'h81, 2'b01, memf(8'h0A));
      step2(2'b00, 2'b00, 8'h0B, 8'h81); exp2("rel4", 2'b00, 8'h81, 2'b10, memf(8'h81));

      // back-to-back reads of addr 0..255 by core 0
      for (int i = 0; i < 256; i++) begin
         step2(2'b01, 2'b00, 8'(i), 8'h81);
         exp2($sformatf("b2b%0d", i), 2'b01, 8'(i), (i > 0) ? 2'b01 : 2'b00, memf(8'(i - 1)));
      end
      step2(2'b00, 2'b00, 8'hFF, 8'h81); exp2("b2bend", 2'b00, 8'hFF, 2'b01, memf(8'hFF));
      step2(2'b00, 2'b00, 8'hFF, 8'h81); exp2("b2bidle", 2'b00, 8'hFF, 2'b00, 8'h00);
      chk("b2bidle.busy", 32'(busy2), 32'h0);
      chk("b2bidle.wren", 32'(ct_wren2), 32'h0);

      // NREQ=3 wrap: grant to 2, then cores 0 and 2 -> 0 then 2
      step3(3'b100, 8'h00, 8'h00, 8'h30); exp3("wr1", 3'b100, 8'h30, 3'b000, 8'h00);
      step3(3'b101, 8'h31, 8'h00, 8'h32); exp3("wr2", 3'b001, 8'h31, 3'b000, 8'h00);
      step3(3'b101, 8'h33, 8'h00, 8'h32); exp3("wr3", 3'b100, 8'h32, 3'b000, 8'h00);
      step3(3'b000, 8'h33, 8'h00, 8'h32); exp3("wr4", 3'b000, 8'h32, 3'b100, memf(8'h30));
      step3(3'b000, 8'h33, 8'h00, 8'h32); exp3("wr5", 3'b000, 8'h32, 3'b001, memf(8'h31));
      step3(3'b000, 8'h33, 8'h00, 8'h32); exp3("wr6", 3'b000, 8'h32, 3'b100, memf(8'h32));
      chk("wr6.busy", 32'(busy3), 32'h1);
      step3(3'b000, 8'h33, 8'h00, 8'h32); exp3("wr7", 3'b000, 8'h32, 3'b000, 8'h00);
      chk("wr7.busy", 32'(busy3), 32'h0);

      // reset with two reads in flight
      step3(3'b011, 8'h40, 8'h41, 8'h32); exp3("rf1", 3'b001, 8'h40, 3'b000, 8'h00);
      step3(3'b010, 8'h40, 8'h41, 8'h32); exp3("rf2", 3'b010, 8'h41, 3'b000, 8'h00);
      @(negedge clk);
      rst3 = 1'b1;
      req3 = 3'b000;
      #1;
      chk("rf3.gnt", 32'(gnt3), 32'h0);
      chk("rf3.rvalid", 32'(rvalid3), 32'h0);
      @(negedge clk);
      rst3 = 1'b0;
      #1;
      chk("rf4.rvalid", 32'(rvalid3), 32'h0);
      chk("rf4.gnt", 32'(gnt3), 32'h0);
      chk("rf4.addr", 32'(ct_addr3), 32'h0);
      chk("rf4.rdata", 32'(rdata3), 32'h0);
      chk("rf4.busy", 32'(busy3), 32'h0);
      chk("rf4.wren", 32'(ct_wren3), 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk($sformatf("rf%0d.rvalid", 5 + i), 32'(rvalid3), 32'h0);
      end
      // rr pointer back at 0: cores 1 and 2 request -> core 1 wins
      step3(3'b110, 8'h40, 8'h50, 8'h51); exp3("rf8", 3'b010, 8'h50, 3'b000, 8'h00);
      step3(3'b000, 8'h40, 8'h50, 8'h51); exp3("rf9", 3'b000, 8'h50, 3'b000, 8'h00);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/ct_read_arbiter.md
Name: ct_read_arbiter

Overview:
- Shares the single-port ciphertext memory (ct_mem) between NREQ parallel crack cores inside the multi-core cracker.
- Each core issues byte reads. The arbiter grants one read per cycle using round-robin with optional burst lock.
- It drives the ct_mem address and returns read data, tagged with a per-requester valid pulse, after the memory's fixed read latency.
- Read-only: the write port to ct_mem is tied off.

Parameters:
- NREQ, 2, number of crack-core requesters (2..8).
- RD_LAT, 1, ct_mem read latency in cycles, from address presented to ct_rddata valid (1..3).
- AW, 8, ct_mem address width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  per-core read request; level, held until granted.
- lock  in  NREQ  per-core burst lock; sampled only while that core holds the grant.
- req_addr  in  NREQ*AW  per-core address; slice i belongs to core i; must be stable while req[i]=1.
- gnt  out  NREQ  one-hot grant pulse; address of the granted core is sent to memory this cycle.
- rvalid  out  NREQ  one-hot pulse; rdata is valid for that core this cycle.
- rdata  out  8  read data, broadcast to all cores.
- ct_addr  out  AW  ct_mem address.
- ct_wrdata  out  8  tied to 0.
- ct_wren  out  1  tied to 0.
- ct_rddata  in  8  ct_mem read data.
- busy  out  1  high while any read is in flight or any req is pending.

Behaviour:
- Reset values: gnt=0, rvalid=0, rdata=0, ct_addr=0, busy=0, rr pointer=0, owner=none, in-flight pipeline cleared.
- Arbitration (combinational from registered state, one grant per cycle):
  - If owner is set and req[owner]=1, grant owner.
  - Otherwise grant the first i with req[i]=1, searching from rr_ptr upward with wrap-around modulo NREQ.
- gnt is combinational. ct_addr = req_addr slice of the granted core, driven the same cycle. ct_addr holds its last value when idle.
- On a grant to core g: rr_ptr <= (g+1) mod NREQ. owner <= g if lock[g]=1, else none.
- If the owner drops req, ownership is released that cycle and normal round-robin applies in the same cycle.
- Requester rule: after gnt[i], core i may present a new address and keep req[i] high. Back-to-back reads by the same core are legal at one per cycle.
- Return path: an RD_LAT-deep shift register carries {valid, one-hot id} per grant. At stage RD_LAT, rvalid <= id and rdata <= ct_rddata.
  - rvalid therefore pulses exactly RD_LAT cycles after the matching gnt (rdata/rvalid registered on the data side, aligned to ct_rddata).
  - Returns arrive strictly in grant order. Throughput is one read per cycle.
- No requests: gnt=0. An invalid bubble is shifted into the pipeline.
- Simultaneous release of lock and new req by others: lock is evaluated only at grant time, so the deasserting owner gets that grant and others compete next cycle.
- Reset mid-operation: the pipeline is flushed and no rvalid is emitted for in-flight reads. Requesters must reissue.
- busy = |req | any pipeline valid bit.
- Fairness bound without lock: a core waits at most NREQ-1 cycles. A locked core can starve others; this is intentional for contiguous message reads.

Decomposition:
- Shared package ct_pkg: CT_AW=8, CT_DW=8, CT_RD_LAT=1, typedef ct_addr_t (logic [7:0]), ct_byte_t (logic [7:0]).
- One sub-module is natural: rr_pick (NREQ-wide round-robin priority picker: req, rr_ptr -> one-hot gnt, encoded index). The return pipeline stays in the top.

Test Plan:
- Single core: req[0] with addr=0x05 and mem[5]=0x3C -> gnt[0] the same cycle; rvalid[0]=1 and rdata=0x3C exactly RD_LAT cycles later; busy returns to 0 afterwards.
- Both cores request every cycle, no lock, NREQ=2 -> grants alternate 0,1,0,1. Each rvalid carries its own addressed byte in order. No cycle has two gnt bits set.
- Core 0 with lock=1 reads addr 1..4 while core 1 requests -> four consecutive gnt[0]. gnt[1] appears the cycle after core 0 deasserts req.
- rr wrap with NREQ=3: cores 0 and 2 request after a grant to 2 -> next grant goes to 0, then 2.
- rst asserted with two reads in flight -> no rvalid in following cycles; all outputs at reset values the next cycle; ct_wren=0 throughout.
- Back-to-back single-core reads of addr 0..255 -> 256 rvalid pulses with bytes matching memory. Total time = 256+RD_LAT cycles.
